// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, character width and a parity helper
// usable by the receiver, the transmitter and bench models.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_rx_state_e;

  // Parity bit a transmitter appends so that data plus parity has the requested sense.
  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Host-side bundle of the UART receiver: line/enable towards the framer, character and
// status flags back out of it.
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic                   rx_en;
  logic                   rx;
  logic [UART_DATA_W-1:0] data_out;
  logic                   data_ready;
  logic                   parity_error;
  logic                   stop_error;

  modport master (
    output rx_en,
    output rx,
    input  data_out,
    input  data_ready,
    input  parity_error,
    input  stop_error
  );

  modport slave (
    input  rx_en,
    input  rx,
    output data_out,
    output data_ready,
    output parity_error,
    output stop_error
  );

endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous bit; ResetVal sets the value both
// stages take during reset so an idle line does not look like an edge when reset releases.
module uart_sync2 #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronised rx, mid-bit sampling FSM, registered character and flags.
// Define UART_RX_PARITY_EN to expect a parity bit between D7 and stop (11-bit frame).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  uart_rx_frame_if.slave bus_io
);

  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW   = $clog2(UART_DATA_W);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitM1  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(UART_DATA_W - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_e StAfterData = StParity;
`else
  localparam uart_rx_state_e StAfterData = StStop;
`endif

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks
    $error("CLKS_PER_BIT must be even and at least 4");
  end
  if (PARITY_ODD > 1) begin : g_bad_odd
    $error("PARITY_ODD must be 0 or 1");
  end

  logic                   rx_s, rx_prev_q;
  uart_rx_state_e         state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   serr_q, serr_d;
  logic                   cnt_zero, start_edge, last_bit;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   perr_q, perr_d;
`endif

  uart_sync2 #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (bus_io.rx),
    .q_o   (rx_s)
  );

  assign cnt_zero   = (cnt_q == '0);
  assign last_bit   = (idx_q == LastIdx);
  // A held-low line never re-triggers: a start needs rx_s seen high on the previous cycle.
  assign start_edge = bus_io.rx_en & rx_prev_q & ~rx_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_edge) state_d = StStart;
      StStart:  if (cnt_zero) state_d = rx_s ? StIdle : StData;
      StData:   if (cnt_zero && last_bit) state_d = StAfterData;
      StParity: if (cnt_zero) state_d = StStop;
      StStop:   if (cnt_zero) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_zero ? BitM1 : cnt_q - CntW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ready_d = 1'b0;
    serr_d  = serr_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = perr_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = HalfM1;
      end
      StStart: begin
        idx_d = '0;
      end
      StData: begin
        if (cnt_zero) begin
          shreg_d[idx_q] = rx_s;
          idx_d          = idx_q + IdxW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_zero) par_bad_d = (uart_parity(shreg_q, PARITY_ODD != 0) != rx_s);
      end
`endif
      StStop: begin
        if (cnt_zero) begin
          data_d  = shreg_q;
          ready_d = 1'b1;
          serr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d  = par_bad_q;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      serr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_prev_q <= rx_s;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      serr_q    <= serr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus_io.data_out   = data_q;
  assign bus_io.data_ready = ready_q;
  assign bus_io.stop_error = serr_q;
`ifdef UART_RX_PARITY_EN
  assign bus_io.parity_error = perr_q;
`else
  assign bus_io.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frames built bit by bit on the line, expected strobes predicted
// from frame start time, character contents and parity/stop rules.
module tb_uart_rx_frame;

  localparam int unsigned C   = 16;
  localparam int unsigned H   = C / 2;
  localparam int unsigned Odd = 0;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned F = 11;
`else
  localparam int unsigned F = 10;
`endif
  localparam int unsigned Lat = 3 + H + (F - 1) * C;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       se;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  ev_t  last_exp = '{cyc: 0, d: 8'h00, pe: 1'b0, se: 1'b0};
  ev_t  obs[64];
  int   obs_n = 0;
  int   rd = 0;

  uart_rx_frame_if bus ();

  uart_rx_frame #(
    .CLKS_PER_BIT(C),
    .PARITY_ODD  (Odd)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records every strobe with the cycle number at which it is visible.
  always @(negedge clk) begin
    if (bus.data_ready === 1'b1 && obs_n < 64) begin
      obs[obs_n] <= '{cyc: cyc + 1, d: bus.data_out, pe: bus.parity_error,
                      se: bus.stop_error};
      obs_n      <= obs_n + 1;
    end
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting just after a rising edge; records the predicted delivery.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input bit expect_it, input int drop_en_bit);
    logic [10:0] bits;
    ev_t e;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    bits[9]   = (F == 11) ? par : stp;
    bits[10]  = stp;
    e.cyc = cyc + 1 + Lat;
    e.d   = d;
    e.pe  = (F == 11) && ((($countones(d) + int'(par)) % 2) != Odd);
    e.se  = ~stp;
    if (expect_it) begin
      exp_q.push_back(e);
      last_exp = e;
    end
    for (int i = 0; i < int'(F); i++) begin
      if (i == drop_en_bit) bus.rx_en = 1'b0;
      bus.rx = bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
    bus.rx = 1'b1;
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (($countones(d) % 2) != Odd);
  endfunction

  task automatic test_reset;
    bus.rx    = 1'b1;
    bus.rx_en = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.data_out !== 8'h00) begin
      n_bad++; $display("FAIL reset data_out: got %h want 00", bus.data_out);
    end
    n_cmp++;
    if ({bus.data_ready, bus.parity_error, bus.stop_error} !== 3'b000) begin
      n_bad++; $display("FAIL reset flags: got %b want 000",
                        {bus.data_ready, bus.parity_error, bus.stop_error});
    end
    rst_n = 1'b1;
    idle(2 * C);
    n_cmp++;
    if (obs_n != 0 || bus.data_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset idle_strobe: got %0d strobes want 0", obs_n);
    end
  endtask

  task automatic test_basic;
    ev_t e, o;
    send_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b1, -1);
    idle(2 * C);
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front(); o = obs[rd]; rd++;
      n_cmp++;
      if (o.cyc !== e.cyc) begin
        n_bad++; $display("FAIL basic cycle: got %0d want %0d", o.cyc, e.cyc);
      end
      n_cmp++;
      if ({o.d, o.pe, o.se} !== {e.d, e.pe, e.se}) begin
        n_bad++; $display("FAIL basic char: got %h/%b%b want %h/%b%b",
                          o.d, o.pe, o.se, e.d, e.pe, e.se);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || rd != obs_n) begin
      n_bad++; $display("FAIL basic count: got %0d extra want %0d missing 0",
                        obs_n - rd, exp_q.size());
      exp_q.delete(); rd = obs_n;
    end
    n_cmp++;
    if (bus.data_out !== 8'hA5) begin
      n_bad++; $display("FAIL basic hold: got %h want a5", bus.data_out);
    end
  endtask

  task automatic test_errors;
    ev_t e, o;
    send_frame(8'hA5, ~good_par(8'hA5), 1'b1, 1'b1, -1);
    idle(4);
    send_frame(8'h3C, good_par(8'h3C), 1'b1, 1'b1, -1);
    idle(4);
    send_frame(8'h5A, good_par(8'h5A), 1'b0, 1'b1, -1);
    idle(2 * C);
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front(); o = obs[rd]; rd++;
      n_cmp++;
      if (o.cyc !== e.cyc) begin
        n_bad++; $display("FAIL errors cycle: got %0d want %0d", o.cyc, e.cyc);
      end
      n_cmp++;
      if ({o.d, o.pe, o.se} !== {e.d, e.pe, e.se}) begin
        n_bad++; $display("FAIL errors char: got %h/%b%b want %h/%b%b",
                          o.d, o.pe, o.se, e.d, e.pe, e.se);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || rd != obs_n) begin
      n_bad++; $display("FAIL errors count: got %0d extra want %0d missing 0",
                        obs_n - rd, exp_q.size());
      exp_q.delete(); rd = obs_n;
    end
  endtask

  task automatic test_glitch;
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(3 * C);
    n_cmp++;
    if (rd != obs_n) begin
      n_bad++; $display("FAIL glitch strobe: got %0d strobes want 0", obs_n - rd);
      rd = obs_n;
    end
    n_cmp++;
    if ({bus.data_out, bus.parity_error, bus.stop_error} !==
        {last_exp.d, last_exp.pe, last_exp.se}) begin
      n_bad++; $display("FAIL glitch hold: got %h/%b%b want %h/%b%b", bus.data_out,
                        bus.parity_error, bus.stop_error, last_exp.d, last_exp.pe, last_exp.se);
    end
  endtask

  task automatic test_break;
    ev_t e, o;
    e.cyc = cyc + 1 + Lat;
    e.d   = 8'h00;
    e.pe  = (F == 11) && (0 != Odd);
    e.se  = 1'b1;
    exp_q.push_back(e);
    last_exp = e;
    bus.rx = 1'b0;
    repeat (3 * F * C) @(posedge clk);
    #1;
    idle(2 * C);
    send_frame(8'h81, good_par(8'h81), 1'b1, 1'b1, -1);
    idle(4);
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front(); o = obs[rd]; rd++;
      n_cmp++;
      if (o.cyc !== e.cyc) begin
        n_bad++; $display("FAIL break cycle: got %0d want %0d", o.cyc, e.cyc);
      end
      n_cmp++;
      if ({o.d, o.pe, o.se} !== {e.d, e.pe, e.se}) begin
        n_bad++; $display("FAIL break char: got %h/%b%b want %h/%b%b",
                          o.d, o.pe, o.se, e.d, e.pe, e.se);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || rd != obs_n) begin
      n_bad++; $display("FAIL break count: got %0d extra want %0d missing 0",
                        obs_n - rd, exp_q.size());
      exp_q.delete(); rd = obs_n;
    end
  endtask

  task automatic test_back_to_back(input bit drop_en);
    ev_t e, o;
    send_frame(8'h00, good_par(8'h00), 1'b1, 1'b1, drop_en ? 3 : -1);
    send_frame(8'hFF, good_par(8'hFF), 1'b1, !drop_en, -1);
    idle(4);
    bus.rx_en = 1'b1;
    idle(C);
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front(); o = obs[rd]; rd++;
      n_cmp++;
      if (o.cyc !== e.cyc) begin
        n_bad++; $display("FAIL b2b(en_drop=%0d) cycle: got %0d want %0d", drop_en, o.cyc, e.cyc);
      end
      n_cmp++;
      if ({o.d, o.pe, o.se} !== {e.d, e.pe, e.se}) begin
        n_bad++; $display("FAIL b2b(en_drop=%0d) char: got %h/%b%b want %h/%b%b", drop_en,
                          o.d, o.pe, o.se, e.d, e.pe, e.se);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || rd != obs_n) begin
      n_bad++; $display("FAIL b2b(en_drop=%0d) count: got %0d extra want %0d missing 0",
                        drop_en, obs_n - rd, exp_q.size());
      exp_q.delete(); rd = obs_n;
    end
  endtask

  task automatic test_random;
    ev_t e, o;
    logic [7:0] d;
    logic par, stp;
    int gap;
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom);
      par = good_par(d) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 12);
      if (!stp && gap == 0) gap = 1;
      send_frame(d, par, stp, 1'b1, -1);
      if (gap > 0) idle(gap);
    end
    idle(4);
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front(); o = obs[rd]; rd++;
      n_cmp++;
      if (o.cyc !== e.cyc) begin
        n_bad++; $display("FAIL random cycle: got %0d want %0d", o.cyc, e.cyc);
      end
      n_cmp++;
      if ({o.d, o.pe, o.se} !== {e.d, e.pe, e.se}) begin
        n_bad++; $display("FAIL random char: got %h/%b%b want %h/%b%b",
                          o.d, o.pe, o.se, e.d, e.pe, e.se);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || rd != obs_n) begin
      n_bad++; $display("FAIL random count: got %0d extra want %0d missing 0",
                        obs_n - rd, exp_q.size());
      exp_q.delete(); rd = obs_n;
    end
  endtask

  task automatic test_reset_mid;
    ev_t e, o;
    logic [9:0] bits;
    bits = {1'b1, 8'h6B, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.rx = bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
    bus.rx = bits[4];
    repeat (H) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_out, bus.data_ready, bus.parity_error, bus.stop_error} !== 11'h000) begin
      n_bad++; $display("FAIL reset_mid outputs: got %h/%b%b%b want 00/000", bus.data_out,
                        bus.data_ready, bus.parity_error, bus.stop_error);
    end
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2 * F * C);
    n_cmp++;
    if (rd != obs_n) begin
      n_bad++; $display("FAIL reset_mid partial: got %0d strobes want 0", obs_n - rd);
      rd = obs_n;
    end
    send_frame(8'hC3, good_par(8'hC3), 1'b1, 1'b1, -1);
    idle(4);
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front(); o = obs[rd]; rd++;
      n_cmp++;
      if ({o.cyc, o.d, o.pe, o.se} !== {e.cyc, e.d, e.pe, e.se}) begin
        n_bad++; $display("FAIL reset_mid frame: got %0d %h/%b%b want %0d %h/%b%b",
                          o.cyc, o.d, o.pe, o.se, e.cyc, e.d, e.pe, e.se);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || rd != obs_n) begin
      n_bad++; $display("FAIL reset_mid count: got %0d extra want %0d missing 0",
                        obs_n - rd, exp_q.size());
      exp_q.delete(); rd = obs_n;
    end
  endtask

  initial begin
    bus.rx    = 1'b1;
    bus.rx_en = 1'b1;
    test_reset();
    test_basic();
    test_errors();
    test_glitch();
    test_break();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
